// File: rtl/vend_fsm_param.sv
// rtl/vend_fsm_param.sv - parametrised coin vending controller with change return
module vend_fsm_param #(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 40,
  parameter int CREDIT_W   = 6,
  parameter int ENABLE_25  = 1,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [CNT_W-1:0]    sales_count
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  // Extended-width constants for the overflow-safe credit+coin sum
  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   V5_X    = (CREDIT_W+1)'(5);
  localparam logic [CREDIT_W:0]   V10_X   = (CREDIT_W+1)'(10);
  localparam logic [CREDIT_W:0]   V25_X   = (CREDIT_W+1)'(25);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] FIVE_C  = CREDIT_W'(5);
  localparam logic [CNT_W-1:0]    ONE_CNT = CNT_W'(1);

  state_t            state;
  logic [CREDIT_W:0] coin_val;
  logic              coin_ok;
  logic [CREDIT_W:0] sum;
  logic              over;

  // Decode the coin code into a value; 25 is refused when disabled
  always_comb begin
    coin_val = '0;
    coin_ok  = 1'b1;
    case (coin)
      2'b01:   coin_val = V5_X;
      2'b10:   coin_val = V10_X;
      2'b11: begin
        if (ENABLE_25 != 0) coin_val = V25_X;
        else                coin_ok  = 1'b0;
      end
      default: coin_val = '0;
    endcase
    sum  = {1'b0, credit} + coin_val;
    over = (sum > MAX_X);
  end

  // Controller state, credit, sales counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= COLLECT;
      credit       <= '0;
      sales_count  <= '0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      case (state)
        COLLECT: begin
          if (cancel) begin
            // cancel has priority: any coin this cycle is refused
            coin_reject <= (coin != 2'b00);
            if (credit != '0) begin
              state        <= CHANGE;
              change_pulse <= 1'b1;
              busy         <= 1'b1;
            end
          end else if (coin != 2'b00) begin
            if (!coin_ok || over) begin
              coin_reject <= 1'b1;
            end else begin
              credit <= sum[CREDIT_W-1:0];
              if (sum >= PRICE_X) begin
                state    <= VEND;
                dispense <= 1'b1;
                busy     <= 1'b1;
              end
            end
          end
        end
        VEND: begin
          coin_reject <= (coin != 2'b00);
          credit      <= credit - PRICE_C;
          sales_count <= sales_count + ONE_CNT;
          dispense    <= 1'b0;
          if (credit != PRICE_C) begin
            state        <= CHANGE;
            change_pulse <= 1'b1;
          end else begin
            state <= COLLECT;
            busy  <= 1'b0;
          end
        end
        CHANGE: begin
          coin_reject <= (coin != 2'b00);
          credit      <= credit - FIVE_C;
          if (credit == FIVE_C) begin
            state        <= COLLECT;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state        <= COLLECT;
          dispense     <= 1'b0;
          change_pulse <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_fsm_param.sv
// tb/tb_vend_fsm_param.sv - self-checking bench for vend_fsm_param across four parameter sets
module tb_vend_fsm_param;

    logic       clk;
    logic       rst;
    logic [1:0] coin;
    logic       cancel;

    logic       disp   [4];
    logic       chg    [4];
    logic       rej    [4];
    logic       busy_o [4];
    logic [5:0] cred   [4];
    logic [7:0] sales_o[4];
    logic [7:0] sales0, sales1, sales2;
    logic [1:0] sales3;

    int n_tests = 0;
    int n_fail  = 0;

    // instance parameters: 0 default, 1 MAX_CREDIT=30, 2 ENABLE_25=0, 3 CNT_W=2
    int p_max [4] = '{40, 30, 40, 40};
    int p_en25[4] = '{1, 1, 0, 1};
    int p_mask[4] = '{255, 255, 255, 3};

    vend_fsm_param u0 (.clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .dispense(disp[0]),
        .change_pulse(chg[0]), .coin_reject(rej[0]), .credit(cred[0]), .busy(busy_o[0]), .sales_count(sales0));
    vend_fsm_param #(.MAX_CREDIT(30)) u1 (.clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .dispense(disp[1]),
        .change_pulse(chg[1]), .coin_reject(rej[1]), .credit(cred[1]), .busy(busy_o[1]), .sales_count(sales1));
    vend_fsm_param #(.ENABLE_25(0)) u2 (.clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .dispense(disp[2]),
        .change_pulse(chg[2]), .coin_reject(rej[2]), .credit(cred[2]), .busy(busy_o[2]), .sales_count(sales2));
    vend_fsm_param #(.CNT_W(2)) u3 (.clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .dispense(disp[3]),
        .change_pulse(chg[3]), .coin_reject(rej[3]), .credit(cred[3]), .busy(busy_o[3]), .sales_count(sales3));

    assign sales_o[0] = sales0;
    assign sales_o[1] = sales1;
    assign sales_o[2] = sales2;
    assign sales_o[3] = {6'b0, sales3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: credit/sales plus a schedule of upcoming busy edges.
    // Each schedule entry = credit_after*4 + change_after*2 + sale_counted.
    int m_credit[4];
    int m_sales [4];
    bit m_disp  [4];
    bit m_chg   [4];
    bit m_rej   [4];
    int mq[4][$];

    task automatic model_edge(input logic r, input logic [1:0] c, input logic can);
        int e, v, rem;
        for (int i = 0; i < 4; i++) begin
            if (!r) begin
                mq[i].delete();
                m_credit[i] = 0; m_sales[i] = 0;
                m_disp[i] = 0; m_chg[i] = 0; m_rej[i] = 0;
            end else if (mq[i].size() > 0) begin
                e = mq[i].pop_front();
                m_credit[i] = e / 4;
                m_chg[i]    = ((e / 2) % 2) == 1;
                m_disp[i]   = 0;
                m_sales[i]  = (m_sales[i] + (e % 2)) & p_mask[i];
                m_rej[i]    = (c != 2'b00);
            end else begin
                m_disp[i] = 0; m_chg[i] = 0; m_rej[i] = 0;
                case (c)
                    2'd1: v = 5;
                    2'd2: v = 10;
                    2'd3: v = (p_en25[i] != 0) ? 25 : -1;
                    default: v = 0;
                endcase
                if (can) begin
                    m_rej[i] = (c != 2'b00);
                    if (m_credit[i] > 0) begin
                        m_chg[i] = 1;
                        for (int x = m_credit[i]; x > 0; x -= 5)
                            mq[i].push_back((x - 5) * 4 + ((x - 5 > 0) ? 2 : 0));
                    end
                end else if (c != 2'b00) begin
                    if (v < 0 || m_credit[i] + v > p_max[i]) begin
                        m_rej[i] = 1;
                    end else begin
                        m_credit[i] += v;
                        if (m_credit[i] >= 15) begin
                            m_disp[i] = 1;
                            rem = m_credit[i] - 15;
                            mq[i].push_back(rem * 4 + ((rem > 0) ? 2 : 0) + 1);
                            for (int x = rem; x > 0; x -= 5)
                                mq[i].push_back((x - 5) * 4 + ((x - 5 > 0) ? 2 : 0));
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [17:0] obs(input int i);
        return {disp[i], chg[i], rej[i], busy_o[i], cred[i], sales_o[i]};
    endfunction

    function automatic logic [17:0] expv(input int i);
        return {m_disp[i], m_chg[i], m_rej[i], m_disp[i] | m_chg[i], 6'(m_credit[i]), 8'(m_sales[i])};
    endfunction

    // one clock: drive inputs, advance the model at the edge, settle past the edge
    task automatic cyc(input logic [1:0] c, input logic can);
        coin = c;
        cancel = can;
        @(posedge clk);
        model_edge(rst, c, can);
        #1;
        coin = 2'b00;
        cancel = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2'b00, 1'b0);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        coin = 2'b01; cancel = 1'b1;
        rst = 1'b0;
        cyc(2'b11, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (obs(i) !== 18'h0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d got=%h want=%h", i, obs(i), 18'h0);
            end
        end
    endtask

    task automatic test_exact_price();
        logic [1:0] tab[5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        int         ecr[5] = '{5, 10, 15, 0, 0};
        do_reset();
        for (int s = 0; s < 5; s++) begin
            cyc(tab[s], 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL exact_price_model inst%0d step%0d got=%h want=%h", i, s, obs(i), expv(i));
                end
            end
            n_tests++;
            if (cred[0] !== 6'(ecr[s]) || disp[0] !== (s == 2) || chg[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL exact_price step%0d credit=%0d disp=%b chg=%b want credit=%0d disp=%b chg=0",
                         s, cred[0], disp[0], chg[0], ecr[s], (s == 2));
            end
        end
        n_tests++;
        if (sales_o[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL exact_price_sales got=%0d want=1", sales_o[0]);
        end
    endtask

    task automatic test_big_change();
        logic [1:0] tab[7] = '{2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        int         ecr[7] = '{10, 35, 20, 15, 10, 5, 0};
        bit         ech[7] = '{0, 0, 1, 1, 1, 1, 0};
        do_reset();
        for (int s = 0; s < 7; s++) begin
            cyc(tab[s], 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL big_change_model inst%0d step%0d got=%h want=%h", i, s, obs(i), expv(i));
                end
            end
            n_tests++;
            if (cred[0] !== 6'(ecr[s]) || chg[0] !== ech[s] || disp[0] !== (s == 1)) begin
                n_fail++;
                $display("FAIL big_change step%0d credit=%0d chg=%b disp=%b want credit=%0d chg=%b disp=%b",
                         s, cred[0], chg[0], disp[0], ecr[s], ech[s], (s == 1));
            end
            if (s == 1) begin
                n_tests++;
                if (cred[1] !== 6'd10 || rej[1] !== 1'b1 || disp[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL max30_reject credit=%0d rej=%b disp=%b want credit=10 rej=1 disp=0",
                             cred[1], rej[1], disp[1]);
                end
                n_tests++;
                if (cred[2] !== 6'd10 || rej[2] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL no25_reject credit=%0d rej=%b want credit=10 rej=1", cred[2], rej[2]);
                end
            end
        end
    endtask

    task automatic test_cancel();
        logic [1:0] tab[6] = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        bit         tcn[6] = '{0, 1, 0, 0, 1, 0};
        int         ecr[6] = '{5, 5, 0, 5, 5, 0};
        bit         ech[6] = '{0, 1, 0, 0, 1, 0};
        bit         erj[6] = '{0, 0, 0, 0, 1, 0};
        do_reset();
        for (int s = 0; s < 6; s++) begin
            cyc(tab[s], tcn[s]);
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL cancel_model inst%0d step%0d got=%h want=%h", i, s, obs(i), expv(i));
                end
            end
            n_tests++;
            if (cred[0] !== 6'(ecr[s]) || chg[0] !== ech[s] || rej[0] !== erj[s] || disp[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL cancel step%0d credit=%0d chg=%b rej=%b disp=%b want credit=%0d chg=%b rej=%b disp=0",
                         s, cred[0], chg[0], rej[0], disp[0], ecr[s], ech[s], erj[s]);
            end
        end
        n_tests++;
        if (sales_o[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL cancel_sales got=%0d want=0", sales_o[0]);
        end
    endtask

    task automatic test_coin_in_change();
        logic [1:0] tab[4] = '{2'd2, 2'd2, 2'd1, 2'd0};
        int         ecr[4] = '{10, 20, 5, 0};
        bit         erj[4] = '{0, 0, 0, 1};
        bit         ech[4] = '{0, 0, 1, 0};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            // the 5-coin lands while the VEND edge is leaving; retime it into CHANGE
            cyc((s == 2) ? 2'd0 : (s == 3) ? 2'd1 : tab[s], 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL change_coin_model inst%0d step%0d got=%h want=%h", i, s, obs(i), expv(i));
                end
            end
            n_tests++;
            if (cred[0] !== 6'(ecr[s]) || rej[0] !== erj[s] || chg[0] !== ech[s]) begin
                n_fail++;
                $display("FAIL change_coin step%0d credit=%0d rej=%b chg=%b want credit=%0d rej=%b chg=%b",
                         s, cred[0], rej[0], chg[0], ecr[s], erj[s], ech[s]);
            end
        end
    endtask

    task automatic test_reset_in_change();
        do_reset();
        cyc(2'd2, 1'b0);
        cyc(2'd3, 1'b0);
        cyc(2'd0, 1'b0);
        cyc(2'd0, 1'b0);
        n_tests++;
        if (chg[0] !== 1'b1 || cred[0] !== 6'd15) begin
            n_fail++;
            $display("FAIL second_change_cycle chg=%b credit=%0d want chg=1 credit=15", chg[0], cred[0]);
        end
        rst = 1'b0;
        cyc(2'd0, 1'b0);
        rst = 1'b1;
        n_tests++;
        if (obs(0) !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_in_change got=%h want=%h", obs(0), 18'h0);
        end
        for (int s = 0; s < 4; s++) begin
            cyc(2'd0, 1'b0);
            n_tests++;
            if (chg[0] !== 1'b0 || cred[0] !== 6'd0) begin
                n_fail++;
                $display("FAIL post_reset_idle step%0d chg=%b credit=%0d want chg=0 credit=0", s, chg[0], cred[0]);
            end
        end
    endtask

    task automatic test_sales_wrap();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 4; s++) begin
                cyc((s < 3) ? 2'd1 : 2'd0, 1'b0);
                for (int i = 0; i < 4; i++) begin
                    n_tests++;
                    if (obs(i) !== expv(i)) begin
                        n_fail++;
                        $display("FAIL wrap_model inst%0d sale%0d step%0d got=%h want=%h", i, k, s, obs(i), expv(i));
                    end
                end
            end
        end
        n_tests++;
        if (sales_o[3] !== 8'd0) begin
            n_fail++;
            $display("FAIL cnt2_wrap got=%0d want=0", sales_o[3]);
        end
        n_tests++;
        if (sales_o[0] !== 8'd4) begin
            n_fail++;
            $display("FAIL cnt8_sales got=%0d want=4", sales_o[0]);
        end
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic       cn;
        do_reset();
        for (int s = 0; s < 1500; s++) begin
            c  = ($urandom_range(2) == 0) ? 2'd0 : 2'($urandom_range(3));
            cn = ($urandom_range(15) == 0);
            rst = ($urandom_range(149) != 0);
            cyc(c, cn);
            rst = 1'b1;
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL random_model inst%0d cycle%0d got=%h want=%h", i, s, obs(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        coin = 2'b00;
        cancel = 1'b0;
        #1;
        test_reset();
        test_exact_price();
        test_big_change();
        test_cancel();
        test_coin_in_change();
        test_reset_in_change();
        test_sales_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised vending controller, successor to the fixed 15-unit two-coin vending FSM. It accepts 5/10/25-unit coins and accumulates credit in a counter. It vends once credit reaches a parametrised price, then returns change as a train of single 5-unit pulses. It also supports cancel/refund, coin rejection and a running sales count. It sits between the coin-acceptor front end and the dispenser/change-hopper drivers.

## Interface
- PRICE, 15: item price in units; multiple of 5, ≥ 5.
- MAX_CREDIT, 40: credit ceiling; multiple of 5, ≥ PRICE, < 2^CREDIT_W.
- CREDIT_W, 6: credit register width.
- ENABLE_25, 1: when 0, the 25-unit coin code is rejected.
- CNT_W, 8: sales counter width.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- coin  in  2  coin code, valid for one cycle: 00 none, 01 = 5, 10 = 10, 11 = 25.
- cancel  in  1  refund request; level sampled each cycle.
- dispense  out  1  high for exactly one cycle per sale.
- change_pulse  out  1  one high cycle per 5-unit coin returned.
- coin_reject  out  1  one-cycle pulse, registered; the coin sampled on the previous edge was refused.
- credit  out  CREDIT_W  current credit in units.
- busy  out  1  high in VEND and CHANGE.
- sales_count  out  CNT_W  completed sales; wraps modulo 2^CNT_W.

## Operation
- States: COLLECT, VEND, CHANGE. dispense = (state==VEND); change_pulse = (state==CHANGE); busy = dispense | change_pulse.
- Coin value v: 01→5, 10→10, 11→25 (11→invalid if ENABLE_25=0). 00 is never rejected.
- COLLECT, cancel=1:
  - Any coin that cycle is rejected.
  - If credit>0 → CHANGE (full refund).
  - Otherwise stay in COLLECT.
- COLLECT, valid coin, cancel=0:
  - If credit+v > MAX_CREDIT → reject; credit unchanged.
  - Else credit ← credit+v.
  - If the new credit ≥ PRICE → VEND.
- COLLECT, invalid coin → reject.
- VEND: on the edge leaving VEND:
  - credit ← credit−PRICE; sales_count ← sales_count+1.
  - Next state is CHANGE if the remainder > 0, else COLLECT.
- CHANGE: each edge credit ← credit−5; when credit is 5 at the edge, next state is COLLECT.
- Coins arriving in VEND or CHANGE are rejected; credit is unaffected.
- cancel is ignored in VEND and CHANGE.
- Arithmetic: credit+v is computed at CREDIT_W+1 bits before the MAX_CREDIT compare. Credit never exceeds MAX_CREDIT and never goes negative.

## Timing
- Reset (rst low at an edge):
  - state=COLLECT; credit=0; sales_count=0; dispense=0; change_pulse=0; coin_reject=0; busy=0.
  - Overrides all other inputs.
- Reset during VEND or CHANGE: outstanding credit is discarded, no further change_pulse is issued, and the sale is not counted if VEND had not completed.
- Coin sampled at edge k:
  - credit is visible after edge k.
  - If the threshold is reached, dispense is high from edge k to edge k+1.
  - change_pulse follows from edge k+1 for remainder/5 consecutive cycles.
- Latency coin→dispense is 1 edge. The sale is complete (back in COLLECT) after 1+remainder/5 further edges.
- Cancel sampled at edge k with credit c>0: c/5 change_pulse cycles starting at edge k, and no dispense.
- coin_reject is high in the cycle after the offending sample edge.
- Simultaneous cancel and coin in COLLECT: cancel wins and the coin is rejected.
- sales_count wraps from 2^CNT_W−1 to 0 without a flag.

## Test plan
1. PRICE=15; coins 01,01,01 on consecutive cycles → credit 5,10,15; dispense one cycle after the third edge; zero change_pulse; credit 0; sales_count 1.
2. Coins 10,10 → credit 20; dispense 1 cycle, then exactly 1 change_pulse; credit 0; back in COLLECT.
3. Coins 10, then 11 → credit 35; dispense, then 4 change_pulse cycles; credit steps 20,15,10,5,0. Repeat with MAX_CREDIT=30 → the 25 coin is rejected, credit stays 10, no dispense.
4. Coin 01 then cancel → 1 change_pulse, no dispense, sales_count unchanged. Coin 10 with cancel high in the same cycle while credit=5 → coin_reject, 1 change_pulse, credit 0.
5. Coin 01 during CHANGE → coin_reject, credit sequence unaltered. ENABLE_25=0 with coin 11 in COLLECT → coin_reject, credit unchanged.
6. rst low for one cycle in the second CHANGE cycle of scenario 3 → all outputs 0 the next cycle, no further change_pulse. CNT_W=2 with 4 sales → sales_count returns to 0.
